smg_display_arbiter: RTL and testbench

- Owns the 6-digit AX309 seven-segment display and shares it between two frame requesters, A and B (e.g. EEPROM readback and a local counter), via req/ack handshakes.
- Latches the granted requester's 24-bit BCD frame into a display buffer, but only at a scan-frame boundary, so the display never tears.
- Generates the active-low digit-select scan, left to right, plus the BCD nibble for the currently selected digit, for the downstream segment decoder.

---
 rtl/smg_pkg.sv | 79 +++++++
 rtl/smg_tick_gen.sv | 51 +++++
 rtl/smg_display_arbiter.sv | 145 ++++++++++++++
 tb/tb_smg_display_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/smg_pkg.sv
// smg_pkg: shared constants and helpers for the AX309 six-digit display arbiter.
//
// Contents:
//   SMG_DIGITS    number of digits on the display (6)
//   SMG_BLANK     BCD code the segment decoder renders as an unlit digit
//   SCAN_PATTERN  active-low digit-select word per digit index, leftmost first
//   IDLE/WAIT/ACK arbiter FSM state encoding
//   REQ_A/REQ_B   requester identifiers (also the value driven on owner)
//   scan_of, digit_of, blank_mask, mask_bit: per-digit helpers
//
// The blank helpers are only used when SMG_LEADING_ZERO_BLANK_EN is defined.
package smg_pkg;

    localparam int SMG_DIGITS = 6;
    localparam logic [3:0] SMG_BLANK = 4'hF;

    localparam logic [5:0] SCAN_PATTERN [SMG_DIGITS] = '{
        6'b011111, 6'b101111, 6'b110111, 6'b111011, 6'b111101, 6'b111110
    };

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    function automatic logic [5:0] scan_of(input logic [2:0] idx);
        case (idx)
            3'd0:    scan_of = SCAN_PATTERN[0];
            3'd1:    scan_of = SCAN_PATTERN[1];
            3'd2:    scan_of = SCAN_PATTERN[2];
            3'd3:    scan_of = SCAN_PATTERN[3];
            3'd4:    scan_of = SCAN_PATTERN[4];
            3'd5:    scan_of = SCAN_PATTERN[5];
            default: scan_of = 6'b111111;
        endcase
    endfunction

    // Digit 0 is the leftmost digit and lives in the top nibble.
    function automatic logic [3:0] digit_of(input logic [23:0] frame, input logic [2:0] idx);
        case (idx)
            3'd0:    digit_of = frame[23:20];
            3'd1:    digit_of = frame[19:16];
            3'd2:    digit_of = frame[15:12];
            3'd3:    digit_of = frame[11:8];
            3'd4:    digit_of = frame[7:4];
            3'd5:    digit_of = frame[3:0];
            default: digit_of = 4'h0;
        endcase
    endfunction

    // Bit i set when digit i and every digit to its left are zero.
    // The rightmost digit is never blanked so a zero frame still shows "0".
    function automatic logic [5:0] blank_mask(input logic [23:0] frame);
        logic       zero_so_far;
        logic [5:0] m;
        zero_so_far = 1'b1;
        m = '0;
        for (int i = 0; i < SMG_DIGITS - 1; i++) begin
            zero_so_far = zero_so_far && (digit_of(frame, 3'(i)) == 4'h0);
            m[i] = zero_so_far;
        end
        return m;
    endfunction

    function automatic logic mask_bit(input logic [5:0] m, input logic [2:0] idx);
        case (idx)
            3'd0:    mask_bit = m[0];
            3'd1:    mask_bit = m[1];
            3'd2:    mask_bit = m[2];
            3'd3:    mask_bit = m[3];
            3'd4:    mask_bit = m[4];
            3'd5:    mask_bit = m[5];
            default: mask_bit = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/smg_tick_gen.sv
// smg_tick_gen: digit-slot timebase for the seven-segment scan.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   tick      out  high in the last cycle of a digit slot
//   idx       out  current digit index 0..5 (0 = leftmost)
//   boundary  out  high in the last cycle of digit 5, i.e. the frame edge
//
// Parameter TICK_CYC (2..65535) is the number of cycles per digit slot.
module smg_tick_gen #(
    parameter int unsigned TICK_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    output logic       tick,
    output logic [2:0] idx,
    output logic       boundary
);

    localparam logic [15:0] LAST = 16'(TICK_CYC - 1);

    logic [15:0] count;
    // The scan outputs are registered one edge behind the index, so the
    // first slot after reset would be one cycle short. Holding the counter
    // at zero for the single cycle that follows reset gives that slot its
    // full length and keeps every slot exactly TICK_CYC cycles wide.
    logic        run;

    assign tick     = run && (count == LAST);
    assign boundary = tick && (idx == 3'd5);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            idx   <= '0;
            run   <= 1'b0;
        end else begin
            run <= 1'b1;
            if (run) begin
                if (tick) begin
                    count <= '0;
                    idx   <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
                end else begin
                    count <= count + 16'd1;
                end
            end
        end
    end

endmodule

// File: rtl/smg_display_arbiter.sv
// smg_display_arbiter: shares the six-digit seven-segment display between
// two frame requesters and drives the digit scan.
//
// Ports:
//   CLK          in   system clock, rising edge
//   RST          in   synchronous active-high reset
//   a_req/b_req  in   requester wants its frame displayed; hold until ack
//   a_data/b_data in  24-bit BCD frame, digit0 (leftmost) in [23:20]
//   a_ack/b_ack  out  one-cycle pulse: that requester's frame was latched
//   scan_sig     out  active-low digit select, bit5 = leftmost digit
//   digit_bcd    out  BCD nibble for the digit selected by scan_sig
//   frame_start  out  one-cycle pulse on the first cycle of digit0
//   owner        out  source of the displayed frame (0 = A, 1 = B)
//
// Handshake: a requester raises req with data and holds both stable until
// its ack pulse; dropping req before the ack withdraws the request. Frames
// are only taken at the frame edge (end of digit5), so the display never
// shows a mix of two frames; the ack coincides with frame_start.
//
// Build option SMG_LEADING_ZERO_BLANK_EN: leading zero digits (never the
// rightmost) are shown as the blank code instead of 0.
module smg_display_arbiter
    import smg_pkg::*;
#(
    parameter int unsigned TICK_CYC = 50000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        a_req,
    input  logic [23:0] a_data,
    output logic        a_ack,
    input  logic        b_req,
    input  logic [23:0] b_data,
    output logic        b_ack,
    output logic [5:0]  scan_sig,
    output logic [3:0]  digit_bcd,
    output logic        frame_start,
    output logic        owner
);

    logic        tick;
    logic        boundary;
    logic [2:0]  idx;
    logic [2:0]  idx_next;

    logic [1:0]  state;
    logic        sel;
    logic        last_grant;
    logic [23:0] frame_buf;

    logic        sel_req;
    logic [23:0] sel_data;
    logic        load;
    logic [23:0] buf_next;
    logic [3:0]  disp_next;

    smg_tick_gen #(.TICK_CYC(TICK_CYC)) u_tick_gen (
        .clk      (CLK),
        .rst      (RST),
        .tick     (tick),
        .idx      (idx),
        .boundary (boundary)
    );

    assign idx_next = tick ? ((idx == 3'd5) ? 3'd0 : idx + 3'd1) : idx;

    assign sel_req  = (sel == REQ_B) ? b_req  : a_req;
    assign sel_data = (sel == REQ_B) ? b_data : a_data;
    assign load     = (state == WAIT) && sel_req && boundary;

    // The display registers look at the buffer as it will be after this
    // edge, so a frame loaded at the boundary shows from its first digit0.
    assign buf_next = load ? sel_data : frame_buf;

`ifdef SMG_LEADING_ZERO_BLANK_EN
    logic [5:0] blank_q;
    logic [5:0] blank_next;

    assign blank_next = load ? blank_mask(sel_data) : blank_q;
    assign disp_next  = mask_bit(blank_next, idx_next) ? SMG_BLANK
                                                       : digit_of(buf_next, idx_next);

    always_ff @(posedge CLK) begin
        if (RST) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_next;
        end
    end
`else
    assign disp_next = digit_of(buf_next, idx_next);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            sel         <= REQ_A;
            last_grant  <= REQ_B;
            frame_buf   <= '0;
            owner       <= REQ_A;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            scan_sig    <= 6'b111111;
            digit_bcd   <= 4'h0;
            frame_start <= 1'b0;
        end else begin
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            frame_buf   <= buf_next;
            scan_sig    <= scan_of(idx_next);
            digit_bcd   <= disp_next;
            // First cycle of digit0, whether after a wrap or after reset.
            frame_start <= (idx_next == 3'd0) && (scan_sig != SCAN_PATTERN[0]);

            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        // On a tie the requester served last time yields.
                        sel   <= (a_req && b_req) ? ~last_grant
                                                  : (b_req ? REQ_B : REQ_A);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!sel_req) begin
                        state <= IDLE;
                    end else if (boundary) begin
                        owner      <= sel;
                        last_grant <= sel;
                        a_ack      <= (sel == REQ_A);
                        b_ack      <= (sel == REQ_B);
                        state      <= ACK;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_smg_display_arbiter.sv
// tb_smg_display_arbiter: bench for smg_display_arbiter with a short digit
// slot (4 cycles, 24-cycle frame). Build with SMG_LEADING_ZERO_BLANK_EN to
// exercise leading-zero blanking; the reference model follows the same macro.
module tb_smg_display_arbiter;

    localparam int T     = 4;
    localparam int FRAME = 6 * T;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req = 1'b0;
    logic [23:0] a_data = '0;
    logic        b_req = 1'b0;
    logic [23:0] b_data = '0;
    logic        a_ack;
    logic        b_ack;
    logic [5:0]  scan_sig;
    logic [3:0]  digit_bcd;
    logic        frame_start;
    logic        owner;

    int          n_tests = 0;
    int          n_fail  = 0;

    // Expected acks in grant order: {requester id, frame data}.
    logic [24:0] exp_q[$];

    // Reference model state: cycle index since reset release, displayed frame,
    // owner, and who was served last (for tie prediction).
    int          t = 0;
    logic [23:0] m_frame = '0;
    logic        m_owner = 1'b0;
    logic        last_id = 1'b1;
    logic        rst_q = 1'b1;

    always #5 clk = ~clk;

    always @(posedge clk) rst_q <= rst;

    smg_display_arbiter #(.TICK_CYC(T)) dut (
        .CLK         (clk),
        .RST         (rst),
        .a_req       (a_req),
        .a_data      (a_data),
        .a_ack       (a_ack),
        .b_req       (b_req),
        .b_data      (b_data),
        .b_ack       (b_ack),
        .scan_sig    (scan_sig),
        .digit_bcd   (digit_bcd),
        .frame_start (frame_start),
        .owner       (owner)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0d)", name, act, exp, t);
        end
    endtask

    // Digit d is shown during cycles [d*T, (d+1)*T) of each frame.
    function automatic logic [5:0] exp_scan(input int tt);
        logic [5:0] one;
        int d;
        one = 6'b100000;
        d = (tt / T) % 6;
        return ~(one >> d);
    endfunction

    function automatic logic [3:0] exp_digit(input logic [23:0] f, input int tt);
        int d;
        logic [23:0] sh;
        d = (tt / T) % 6;
        sh = f >> (20 - 4 * d);
`ifdef SMG_LEADING_ZERO_BLANK_EN
        if (d < 5 && sh == 24'h0) return 4'hF;
`endif
        return sh[3:0];
    endfunction

    // Monitor: compares every cycle against the model, pops on each ack.
    always @(negedge clk) begin
        if (rst_q) begin
            check("rst_scan", scan_sig, 6'b111111);
            check("rst_digit", digit_bcd, 4'h0);
            check("rst_frame_start", frame_start, 1'b0);
            check("rst_acks", {a_ack, b_ack}, 2'b00);
            check("rst_owner", owner, 1'b0);
            t = 0;
            m_frame = '0;
            m_owner = 1'b0;
            exp_q.delete();
        end else begin
            if (a_ack || b_ack) begin
                check("ack_overlap", a_ack && b_ack, 1'b0);
                check("ack_frame_aligned", t % FRAME, 0);
                if (exp_q.size() == 0) begin
                    check("ack_unexpected", {a_ack, b_ack}, 2'b00);
                end else begin
                    logic [24:0] e;
                    e = exp_q.pop_front();
                    check("ack_source", b_ack, e[24]);
                    m_frame = e[23:0];
                    m_owner = e[24];
                end
            end
            check("scan", scan_sig, exp_scan(t));
            check("digit", digit_bcd, exp_digit(m_frame, t));
            check("frame_start", frame_start, (t % FRAME) == 0);
            check("owner", owner, m_owner);
            t++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Wait until the model's next-cycle index lands in [lo, hi] within the frame.
    task automatic wait_window(input int lo, input int hi);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!((t % FRAME) >= lo && (t % FRAME) <= hi) && n < 200);
        check("window_timeout", n < 200, 1'b1);
    endtask

    task automatic wait_ack(input logic id);
        int n;
        logic got;
        n = 0;
        got = 1'b0;
        while (!got && n < 3 * FRAME) begin
            step();
            n++;
            got = id ? b_ack : a_ack;
        end
        check("ack_timeout", got, 1'b1);
    endtask

    // One requester; data changes once before the frame edge, then is
    // scrambled after the ack to show it is no longer sampled.
    task automatic issue_single(input logic id, input logic [23:0] d0, input logic [23:0] d1);
        wait_window(2, 12);
        if (id) begin b_data = d0; b_req = 1'b1; end
        else    begin a_data = d0; a_req = 1'b1; end
        step();
        if (id) b_data = d1; else a_data = d1;
        exp_q.push_back({id, d1});
        wait_ack(id);
        if (id) b_req = 1'b0; else a_req = 1'b0;
        last_id = id;
        a_data = 24'($urandom());
        b_data = 24'($urandom());
    endtask

    // Both request together and hold for n grants; grants must alternate.
    task automatic issue_both(input logic [23:0] da, input logic [23:0] db, input int n);
        logic id;
        wait_window(2, 12);
        a_data = da;
        b_data = db;
        a_req = 1'b1;
        b_req = 1'b1;
        id = ~last_id;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({id, id ? db : da});
            id = ~id;
        end
        id = ~last_id;
        for (int i = 0; i < n; i++) begin
            wait_ack(id);
            last_id = id;
            id = ~id;
        end
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    // A withdraws mid-wait (no ack, display untouched); B is then served.
    task automatic cancel_then_b(input logic [23:0] da, input logic [23:0] db);
        wait_window(2, 8);
        a_data = da;
        a_req = 1'b1;
        repeat ($urandom_range(1, 5)) step();
        a_req = 1'b0;
        repeat (2) step();
        b_data = db;
        b_req = 1'b1;
        exp_q.push_back({1'b1, db});
        wait_ack(1'b1);
        b_req = 1'b0;
        last_id = 1'b1;
    endtask

    // Reset pulse in digit3 while A waits: no ack, everything restarts.
    task automatic reset_mid_wait();
        wait_window(4, 6);
        a_data = 24'h987654;
        a_req = 1'b1;
        wait_window(13, 13);
        rst = 1'b1;
        step();
        rst = 1'b0;
        a_req = 1'b0;
        last_id = 1'b1;
    endtask

    function automatic logic [23:0] rand_frame();
        logic [31:0] r;
        r = $urandom() >> (4 * $urandom_range(0, 6));
        return r[23:0];
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        repeat (3) step();
        rst = 1'b0;
        repeat (30) step();

        issue_single(1'b0, 24'h123456, 24'h123456);
        reset_mid_wait();
        repeat (10) step();
        issue_both(24'h111111, 24'h222222, 3);
        cancel_then_b(24'h555555, 24'h654321);
        issue_single(1'b0, 24'h000405, 24'h000405);
        issue_single(1'b0, 24'h000000, 24'h000000);

        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 3))
                0: issue_single(1'b0, rand_frame(), rand_frame());
                1: issue_single(1'b1, rand_frame(), rand_frame());
                2: issue_both(rand_frame(), rand_frame(), $urandom_range(2, 3));
                default: cancel_then_b(rand_frame(), rand_frame());
            endcase
            repeat ($urandom_range(0, 30)) step();
        end

        repeat (2 * FRAME) step();
        check("exp_q_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
